envelope_vca: RTL and testbench

ENVELOPE_VCA -- requirements
Module: envelope_vca

---
 rtl/envelope_vca.sv | 142 ++++++++++++++
 tb/tb_envelope_vca.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/envelope_vca.sv
// Envelope VCA: shapes an oscillator sample by an envelope level and a master gain.
// Three-stage valid/ready pipeline: S1 envelope multiply, S2 gain multiply,
// S3 round and limit. Envelope and gain are captured with their sample.
// Optional macro ENVELOPE_VCA_SATURATE_EN: clamp the result and flag clipping on clip_o;
// otherwise the result wraps to DATA_WIDTH bits and clip_o is tied low.
module envelope_vca #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned GAIN_WIDTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic signed [DATA_WIDTH-1:0] sample_i,
  input  logic                         sample_valid_i,
  output logic                         sample_ready_o,
  input  logic signed [DATA_WIDTH-1:0] envelope_i,
  input  logic        [GAIN_WIDTH-1:0] gain_i,
  output logic signed [DATA_WIDTH-1:0] sample_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         clip_o
);

  localparam int unsigned PW = 2 * DATA_WIDTH + 1;          // envelope product width
  localparam int unsigned AW = DATA_WIDTH + 1;              // S1 result width
  localparam int unsigned BW = DATA_WIDTH + GAIN_WIDTH + 2; // S2 result width

  localparam logic signed [PW-1:0] RoundS1 = PW'(16384);    // half LSB of Q1.15
  localparam logic signed [BW-1:0] RoundS3 = BW'(2048);     // half LSB of Q4.12

  // Stage state
  logic                         r_s1_valid, r_s2_valid, r_s3_valid;
  logic signed [AW-1:0]         r_s1_a;
  logic        [GAIN_WIDTH-1:0] r_s1_gain;
  logic signed [BW-1:0]         r_s2_b;
  logic signed [DATA_WIDTH-1:0] r_s3_data;

  // Handshake and datapath wires
  logic                         w_s1_en, w_s2_en, w_s3_en, w_in_xfer;
  logic signed [DATA_WIDTH-1:0] w_env;
  logic signed [PW-1:0]         w_prod, w_prod_rnd;
  logic signed [AW-1:0]         w_a;
  logic signed [BW-1:0]         w_b, w_c_full;
  logic signed [DATA_WIDTH-1:0] w_c_lim;
  logic                         w_c_clip;
  logic                         w_unused_a;

  // A stage may load when empty or when its content moves on this cycle.
  assign w_s3_en        = ~r_s3_valid | ready_i;
  assign w_s2_en        = ~r_s2_valid | w_s3_en;
  assign w_s1_en        = ~r_s1_valid | w_s2_en;
  assign w_in_xfer      = sample_valid_i & w_s1_en;
  assign sample_ready_o = w_s1_en;

  // S1: clamp negative envelope to zero, multiply, round half up, drop 15 fraction bits.
  assign w_env      = envelope_i[DATA_WIDTH-1] ? '0 : envelope_i;
  assign w_prod     = PW'(sample_i) * PW'(w_env);
  assign w_prod_rnd = w_prod + RoundS1;
  assign w_a        = w_prod_rnd[DATA_WIDTH+15:15];
  assign w_unused_a = ^{w_prod_rnd[PW-1:DATA_WIDTH+16], w_prod_rnd[14:0]};

  // S2: full-precision gain multiply; gain is unsigned so it is zero-extended.
  assign w_b = BW'(r_s1_a) * BW'($signed({1'b0, r_s1_gain}));

  // S3: round half up and drop 12 fraction bits.
  assign w_c_full = (r_s2_b + RoundS3) >>> 12;

`ifdef ENVELOPE_VCA_SATURATE_EN
  localparam logic signed [BW-1:0] MaxS = {{(GAIN_WIDTH+3){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [BW-1:0] MinS = {{(GAIN_WIDTH+3){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic r_s3_clip;

  // Clamp to the signed output range and flag when clamping happened.
  always_comb begin
    w_c_lim  = w_c_full[DATA_WIDTH-1:0];
    w_c_clip = 1'b0;
    if (w_c_full > MaxS) begin
      w_c_lim  = MaxS[DATA_WIDTH-1:0];
      w_c_clip = 1'b1;
    end else if (w_c_full < MinS) begin
      w_c_lim  = MinS[DATA_WIDTH-1:0];
      w_c_clip = 1'b1;
    end
  end

  // Clip flag travels with the output sample.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s3_clip <= 1'b0;
    end else if (w_s3_en && r_s2_valid) begin
      r_s3_clip <= w_c_clip;
    end
  end

  assign clip_o = r_s3_clip;
`else
  logic w_unused_c;

  // Two's-complement wrap: keep only the low DATA_WIDTH bits.
  assign w_c_lim    = w_c_full[DATA_WIDTH-1:0];
  assign w_c_clip   = 1'b0;
  assign w_unused_c = ^{w_c_full[BW-1:DATA_WIDTH], w_c_clip};
  assign clip_o     = 1'b0;
`endif

  // Stage valid bits; reset discards everything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
    end else begin
      if (w_s1_en) r_s1_valid <= sample_valid_i;
      if (w_s2_en) r_s2_valid <= r_s1_valid;
      if (w_s3_en) r_s3_valid <= r_s2_valid;
    end
  end

  // Internal data registers need no reset; they are qualified by the valid bits.
  always_ff @(posedge clk_i) begin
    if (w_in_xfer) begin
      r_s1_a    <= w_a;
      r_s1_gain <= gain_i;
    end
    if (w_s2_en && r_s1_valid) begin
      r_s2_b <= w_b;
    end
  end

  // Output data register, reset so sample_o reads zero after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s3_data <= '0;
    end else if (w_s3_en && r_s2_valid) begin
      r_s3_data <= w_c_lim;
    end
  end

  assign sample_o = r_s3_data;
  assign valid_o  = r_s3_valid;

endmodule

// File: tb/tb_envelope_vca.sv
// Bench for envelope_vca: reference model from arithmetic rules, a scoreboard queue, one
// compare process on the falling edge, plus directed literal cases and reset/backpressure runs.
module tb_envelope_vca;

  localparam int DW = 16;
  localparam int GW = 16;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic signed [DW-1:0] sample_i;
  logic                 sample_valid_i;
  logic                 sample_ready_o;
  logic signed [DW-1:0] envelope_i;
  logic        [GW-1:0] gain_i;
  logic signed [DW-1:0] sample_o;
  logic                 valid_o;
  logic                 ready_i;
  logic                 clip_o;

  envelope_vca #(
    .DATA_WIDTH(DW),
    .GAIN_WIDTH(GW)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .sample_i      (sample_i),
    .sample_valid_i(sample_valid_i),
    .sample_ready_o(sample_ready_o),
    .envelope_i    (envelope_i),
    .gain_i        (gain_i),
    .sample_o      (sample_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .clip_o        (clip_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    longint v;
    bit     clip;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_out    = 0;

`ifdef ENVELOPE_VCA_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  function automatic void check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endfunction

  // Expected output from the arithmetic rules, on plain 64-bit integers.
  function automatic longint model(input longint s, input longint e, input longint g,
                                   output bit clip);
    longint a, b, c, lo, hi;
    lo   = -(64'sd1 <<< (DW - 1));
    hi   = (64'sd1 <<< (DW - 1)) - 1;
    if (e < 0) e = 0;
    a    = (s * e + 16384) >>> 15;
    b    = a * g;
    c    = (b + 2048) >>> 12;
    clip = 1'b0;
    if (Sat) begin
      if (c > hi) begin clip = 1'b1; c = hi; end
      else if (c < lo) begin clip = 1'b1; c = lo; end
    end else begin
      c = c & ((64'sd1 <<< DW) - 1);
      if (c > hi) c = c - (64'sd1 <<< DW);
    end
    return c;
  endfunction

  function automatic logic [15:0] rnd_word();
    case ($urandom_range(7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Scoreboard: check the presented output each cycle, then record any input transfer.
  always @(negedge clk_i) begin : mon
    bit     c_l;
    longint v_l;
    if (rst_ni) begin
      if (valid_o) begin
        if (q.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          check("out_data", sample_o, q[0].v);
          check("out_clip", clip_o, q[0].clip);
          if (ready_i) begin
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (sample_valid_i && sample_ready_o) begin
        v_l = model(sample_i, envelope_i, gain_i, c_l);
        q.push_back('{v_l, c_l});
      end
    end
  end

  task automatic wait_drain();
    int k = 0;
    sample_valid_i = 1'b0;
    ready_i        = 1'b1;
    while (q.size() != 0 && k < 50) begin
      @(posedge clk_i);
      #1;
      k++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  // One isolated sample with ready high; checks 3-cycle latency and a literal result.
  task automatic send_one(input int s, input int e, input int g, input int exp_v,
                          input bit exp_c);
    @(posedge clk_i);
    #1;
    ready_i        = 1'b1;
    sample_i       = 16'(s);
    envelope_i     = 16'(e);
    gain_i         = 16'(g);
    sample_valid_i = 1'b1;
    @(negedge clk_i);
    check("one_accept", sample_ready_o, 1);
    @(posedge clk_i);
    #1;
    sample_valid_i = 1'b0;
    envelope_i     = 16'($urandom);
    gain_i         = 16'($urandom);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_i);
      if (k < 3) begin
        check("one_latency_early", valid_o, 0);
      end else begin
        check("one_latency_valid", valid_o, 1);
        check("one_value", sample_o, exp_v);
        check("one_clip", clip_o, exp_c);
      end
    end
  endtask

  // Stream n samples; envelope and gain change every cycle; optional forced stall window.
  task automatic run_stream(input int n, input int stall_at, input int stall_len,
                            input int valid_pct, input int ready_pct, input bit chk_full,
                            output int cycles);
    int sent = 0;
    int cyc  = 0;
    bit acc;
    sample_i       = rnd_word();
    envelope_i     = rnd_word();
    gain_i         = rnd_word();
    sample_valid_i = ($urandom_range(99) < valid_pct);
    ready_i        = ($urandom_range(99) < ready_pct);
    while (sent < n && cyc < 5000) begin
      @(negedge clk_i);
      acc = sample_valid_i && sample_ready_o;
      if (chk_full && stall_len > 0 && cyc == stall_at + stall_len - 1) begin
        check("stall_ready_low", sample_ready_o, 0);
        check("stall_buffered", q.size(), 3);
      end
      @(posedge clk_i);
      #1;
      cyc++;
      if (acc) begin
        sent++;
        sample_i = rnd_word();
      end
      sample_valid_i = (sent < n) && ($urandom_range(99) < valid_pct);
      envelope_i     = rnd_word();
      gain_i         = rnd_word();
      if (stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len) ready_i = 1'b0;
      else ready_i = ($urandom_range(99) < ready_pct);
    end
    check("stream_sent", sent, n);
    sample_valid_i = 1'b0;
    cycles         = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit c_l;
    int cycles;
    int out0;
    int sent;
    bit acc;

    rst_ni         = 1'b0;
    sample_valid_i = 1'b0;
    ready_i        = 1'b1;
    sample_i       = '0;
    envelope_i     = '0;
    gain_i         = '0;

    // Pin the model to hand-computed values.
    check("model_unity", model(16384, 16384, 4096, c_l), 8192);
    check("model_big", model(30000, 32767, 8192, c_l), Sat ? 32767 : -5538);
    check("model_big_clip", c_l, Sat);
    check("model_min", model(-32768, 32767, 4096, c_l), -32767);
    check("model_neg_env", model(12345, -100, 50000, c_l), 0);

    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst_valid_o", valid_o, 0);
    check("rst_clip_o", clip_o, 0);
    check("rst_sample_o", sample_o, 0);
    check("rst_ready_o", sample_ready_o, 1);

    // Literal cases
    send_one(16384, 16384, 4096, 8192, 1'b0);
    wait_drain();
    send_one(30000, 32767, 8192, Sat ? 32767 : -5538, Sat);
    wait_drain();
    send_one(-32768, 32767, 4096, -32767, 1'b0);
    wait_drain();
    send_one(12345, -100, 50000, 0, 1'b0);
    wait_drain();

    // 20-sample stream with a 5-cycle downstream stall
    out0 = n_out;
    run_stream(20, 8, 5, 100, 100, 1'b1, cycles);
    wait_drain();
    check("stall_delivered", n_out - out0, 20);

    // Back-to-back at full throughput: one sample per cycle, no bubbles
    out0 = n_out;
    run_stream(40, 0, 0, 100, 100, 1'b0, cycles);
    check("full_rate_cycles", cycles, 40);
    wait_drain();
    check("full_rate_delivered", n_out - out0, 40);

    // Randomized valid and ready
    out0 = n_out;
    run_stream(300, 0, 0, 80, 70, 1'b0, cycles);
    wait_drain();
    check("random_delivered", n_out - out0, 300);

    // Reset with three samples in flight
    @(posedge clk_i);
    #1;
    ready_i        = 1'b0;
    sample_i       = rnd_word();
    envelope_i     = rnd_word();
    gain_i         = rnd_word();
    sample_valid_i = 1'b1;
    sent           = 0;
    for (int k = 0; k < 10 && sent < 3; k++) begin
      @(negedge clk_i);
      acc = sample_valid_i && sample_ready_o;
      @(posedge clk_i);
      #1;
      if (acc) begin
        sent++;
        sample_i = rnd_word();
      end
      sample_valid_i = (sent < 3);
    end
    @(negedge clk_i);
    check("inflight_count", q.size(), 3);
    check("inflight_ready_low", sample_ready_o, 0);
    #2;
    rst_ni = 1'b0;
    q.delete();
    #1;
    check("midrst_valid_o", valid_o, 0);
    check("midrst_sample_o", sample_o, 0);
    check("midrst_clip_o", clip_o, 0);
    check("midrst_ready_o", sample_ready_o, 1);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni  = 1'b1;
    ready_i = 1'b1;
    repeat (5) begin
      @(negedge clk_i);
      check("post_rst_idle", valid_o, 0);
    end
    send_one(16384, 16384, 4096, 8192, 1'b0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
